// File: rtl/unpacked_array_serializer.sv
// Serializes an N-entry unpacked bit array, element 0 first, onto a 1-bit valid/ready
// stream. A wrapping counter tracks how many complete words have been emitted.

interface uas_store_if #(
    parameter int N = 8
) (
    input logic clk,
    input logic rst,
    input logic load,
    input logic a [N]
);
    logic x [N];

    always_ff @(posedge clk) begin
        if (rst) begin
            foreach (x[k]) x[k] <= 1'b0;
        end else if (load) begin
            foreach (x[k]) x[k] <= a[k];
        end
    end
endinterface

module unpacked_array_serializer #(
    parameter int N     = 8,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_a [N],
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_bit,
    output logic             o_last,
    output logic [CNT_W-1:0] o_count
);
    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               load;

    // Storage is only written on the IDLE->SHIFT transition, so i_a is ignored mid-word.
    uas_store_if #(.N(N)) store (
        .clk  (i_clk),
        .rst  (i_rst),
        .load (load),
        .a    (i_a)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs depend only on state_q, idx_q and storage; inputs only steer next state.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        o_ready = 1'b0;
        o_valid = 1'b0;
        o_bit   = 1'b0;
        o_last  = 1'b0;
        case (state_q)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                o_valid = 1'b1;
                o_bit   = store.x[idx_q];
                o_last  = (idx_q == LAST_IDX);
                if (i_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_count = cnt_q;

endmodule

// File: tb/tb_unpacked_array_serializer.sv
// Randomized bench for unpacked_array_serializer against a queue-based word/beat model,
// plus a second instance with a 2-bit counter for wrap-around.

module tb_unpacked_array_serializer;
    localparam int N = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance (CNT_W = 16)
    logic        rst = 1'b1, valid = 1'b0, ready = 1'b0;
    logic        a [N];
    logic        o_ready, o_valid, o_bit, o_last;
    logic [15:0] o_count;

    // wrap instance (CNT_W = 2)
    logic        rst2 = 1'b1, valid2 = 1'b0, ready2 = 1'b0;
    logic        a2 [N];
    logic        o_ready2, o_valid2, o_bit2, o_last2;
    logic [1:0]  o_count2;

    unpacked_array_serializer #(.N(N), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(o_ready), .i_a(a),
        .o_valid(o_valid), .i_ready(ready), .o_bit(o_bit), .o_last(o_last), .o_count(o_count)
    );

    unpacked_array_serializer #(.N(N), .CNT_W(2)) dut2 (
        .i_clk(clk), .i_rst(rst2), .i_valid(valid2), .o_ready(o_ready2), .i_a(a2),
        .o_valid(o_valid2), .i_ready(ready2), .o_bit(o_bit2), .o_last(o_last2), .o_count(o_count2)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the bits still to be emitted for the current word, and words completed.
    logic        mq [$];
    logic [15:0] m_count = '0;

    function automatic void model_edge();
        if (rst) begin
            mq.delete();
            m_count = '0;
        end else if (mq.size() == 0) begin
            if (valid) for (int k = 0; k < N; k++) mq.push_back(a[k]);
        end else if (ready) begin
            void'(mq.pop_front());
            if (mq.size() == 0) m_count = m_count + 16'd1;
        end
    endfunction

    function automatic logic [19:0] exp_vec();
        logic b;
        b = (mq.size() != 0) ? mq[0] : 1'b0;
        return {mq.size() == 0, mq.size() != 0, b, mq.size() == 1, m_count};
    endfunction

    function automatic logic [19:0] obs_vec();
        return {o_ready, o_valid, o_bit, o_last, o_count};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_a(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) a[k] = v[k];
    endtask

    task automatic rand_a();
        for (int k = 0; k < N; k++) a[k] = 1'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1; rst2 = 1'b1; valid = 1'b0; ready = 1'b0;
        set_a('0);
        for (int k = 0; k < N; k++) a2[k] = 1'b0;
        tick(); tick();
        checks++;
        if (obs_vec() !== 20'h80000) begin
            errors++;
            $display("FAIL reset_values got %h exp %h", obs_vec(), 20'h80000);
        end
        checks++;
        if ({o_ready2, o_valid2, o_bit2, o_last2, o_count2} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_values_wrap got %b exp 100000",
                     {o_ready2, o_valid2, o_bit2, o_last2, o_count2});
        end
        rst = 1'b0; rst2 = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [N-1:0] got;
        logic [15:0]  c0;
        got = '0;
        c0 = o_count;
        set_a(8'h4D);  // elements 1,0,1,1,0,0,1,0
        valid = 1'b1; ready = 1'b1;
        tick();
        valid = 1'b0;
        for (int j = 1; j <= 9; j++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL basic_cycle%0d got %h exp %h", j, obs_vec(), exp_vec());
            end
            if (j <= 8) begin
                got[j-1] = o_bit;
                checks++;
                if ({o_valid, o_last} !== {1'b1, j == 8}) begin
                    errors++;
                    $display("FAIL basic_last_cycle%0d got %b exp %b", j, {o_valid, o_last}, {1'b1, j == 8});
                end
            end else begin
                checks++;
                if ({o_ready, o_valid, o_count} !== {1'b1, 1'b0, c0 + 16'd1}) begin
                    errors++;
                    $display("FAIL basic_done got rdy=%b vld=%b cnt=%0d exp rdy=1 vld=0 cnt=%0d",
                             o_ready, o_valid, o_count, c0 + 16'd1);
                end
            end
            tick();
        end
        checks++;
        if (got !== 8'h4D) begin
            errors++;
            $display("FAIL basic_bits got %h exp 4d", got);
        end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] got;
        int b, stall, last_cyc;
        got = '0; b = 0; stall = 0; last_cyc = -1;
        set_a(8'h4D);
        valid = 1'b1; ready = 1'b1;
        tick();
        valid = 1'b0;
        for (int c = 1; c <= 30 && b < N; c++) begin
            rand_a();
            if ((b == 2 || b == 5) && stall < 3) begin
                ready = 1'b0;
                stall++;
            end else begin
                ready = 1'b1;
                if (b == 2 || b == 5) stall = 0;
            end
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL backpressure_cycle%0d got %h exp %h", c, obs_vec(), exp_vec());
            end
            if (o_valid && ready) begin
                got[b] = o_bit;
                b++;
                if (b == N) last_cyc = c;
            end
            tick();
        end
        ready = 1'b1;
        checks++;
        if (got !== 8'h4D || last_cyc != 14) begin
            errors++;
            $display("FAIL backpressure_seq got bits=%h last=%0d exp bits=4d last=14", got, last_cyc);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] c0;
        c0 = o_count;
        set_a('1);
        valid = 1'b1; ready = 1'b1;
        tick();
        set_a('0);
        for (int c = 1; c <= 17; c++) begin
            if (c >= 10) valid = 1'b0;
            checks++;
            if (obs_vec() !== exp_vec() || {o_valid, o_bit} !== {c != 9, c < 9}) begin
                errors++;
                $display("FAIL back_to_back_cycle%0d got %h exp %h vld/bit exp %b",
                         c, obs_vec(), exp_vec(), {c != 9, c < 9});
            end
            tick();
        end
        checks++;
        if (o_count !== c0 + 16'd2 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL back_to_back_count got %0d exp %0d", o_count, c0 + 16'd2);
        end
    endtask

    task automatic test_random();
        logic [15:0] c0;
        int cyc;
        c0 = m_count;
        cyc = 0;
        while (16'(m_count - c0) < 16'd6 && cyc < 600) begin
            valid = 1'($urandom);
            ready = ($urandom_range(0, 3) != 0);
            rand_a();
            tick();
            cyc++;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_cycle%0d got %h exp %h", cyc, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (16'(m_count - c0) < 16'd6) begin
            errors++;
            $display("FAIL random_timeout got %0d words exp 6", 16'(m_count - c0));
        end
        valid = 1'b0; ready = 1'b1;
        for (int i = 0; i < N + 1; i++) tick();
    endtask

    task automatic test_reset_mid_word();
        logic [N-1:0] pat, got;
        got = '0;
        rand_a();
        valid = 1'b1; ready = 1'b1;
        tick();
        valid = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        rst = 1'b1;  // cycle k+5 presents element 4
        tick();
        rst = 1'b0;
        checks++;
        if ({o_valid, o_ready, o_count} !== {1'b0, 1'b1, 16'd0} || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_mid_word got vld=%b rdy=%b cnt=%0d exp vld=0 rdy=1 cnt=0",
                     o_valid, o_ready, o_count);
        end
        pat = N'($urandom);
        set_a(pat);
        valid = 1'b1;
        tick();
        valid = 1'b0;
        for (int j = 0; j < N; j++) begin
            rand_a();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reload_beat%0d got %h exp %h", j, obs_vec(), exp_vec());
            end
            got[j] = o_bit;
            tick();
        end
        checks++;
        if (got !== pat || o_count !== 16'd1) begin
            errors++;
            $display("FAIL reload_word got bits=%h cnt=%0d exp bits=%h cnt=1", got, o_count, pat);
        end
    endtask

    task automatic test_wrap();
        logic [1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        ready2 = 1'b1;
        for (int w = 0; w < 5; w++) begin
            for (int k = 0; k < N; k++) a2[k] = 1'($urandom);
            valid2 = 1'b1;
            tick();
            valid2 = 1'b0;
            for (int c = 0; c < N; c++) tick();
            checks++;
            if ({o_ready2, o_valid2, o_bit2, o_last2, o_count2} !== {4'b1000, exp_cnt[w]}) begin
                errors++;
                $display("FAIL wrap_word%0d got rdy=%b vld=%b cnt=%0d exp rdy=1 vld=0 cnt=%0d",
                         w, o_ready2, o_valid2, o_count2, exp_cnt[w]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid_word();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
